pin_output_mux_seq: RTL and testbench

//  Registered, parametrised GPIO output arbiter for the PIO fabric. Per core, merges FSM drive/output by fixed or

---
 rtl/pin_output_mux_seq.sv | 129 ++++++++++++
 tb/tb_pin_output_mux_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pin_output_mux_seq.sv
// pin_output_mux_seq: registered GPIO output arbiter, per-core FSM merge and per-pin glitch-free core handover
module pin_output_mux_seq #(
  parameter int NUM_CORES = 4,
  parameter int NUM_FSMS = 4,
  parameter int NUM_PINS = 32,
  parameter int HANDOVER_CYCLES = 2,
  localparam int CW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1,
  localparam int FW = NUM_FSMS > 1 ? $clog2(NUM_FSMS) : 1,
  localparam int PW = NUM_PINS > 1 ? $clog2(NUM_PINS) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CORES*NUM_FSMS*NUM_PINS-1:0] fsm_output,
  input  logic [NUM_CORES*NUM_FSMS*NUM_PINS-1:0] fsm_drive,
  input  logic [NUM_CORES-1:0]                   rr_enable,
  input  logic [NUM_CORES-1:0]                   rr_step,
  input  logic                                   cfg_we,
  input  logic [PW-1:0]                          cfg_pin,
  input  logic [CW-1:0]                          cfg_core,
  input  logic [NUM_PINS-1:0]                    conflict_clear,
  output logic [NUM_PINS-1:0]                    gpio_output,
  output logic [NUM_PINS-1:0]                    gpio_drive,
  output logic [NUM_PINS*CW-1:0]                 core_select_q,
  output logic [NUM_PINS-1:0]                    handover_busy,
  output logic [NUM_PINS-1:0]                    conflict
);
  localparam int HW = HANDOVER_CYCLES > 1 ? $clog2(HANDOVER_CYCLES) : 1;
  typedef enum logic {ACTIVE, RELEASE} state_t;
  state_t              r_state [NUM_PINS];
  state_t              w_state_nx [NUM_PINS];
  logic [CW-1:0]       r_sel [NUM_PINS];
  logic [CW-1:0]       w_sel_nx [NUM_PINS];
  logic [CW-1:0]       r_tgt [NUM_PINS];
  logic [CW-1:0]       w_tgt_nx [NUM_PINS];
  logic [HW-1:0]       r_hcnt [NUM_PINS];
  logic [HW-1:0]       w_hcnt_nx [NUM_PINS];
  logic [FW-1:0]       r_rr_ptr [NUM_CORES];
  logic [NUM_PINS-1:0] w_core_drv [NUM_CORES];
  logic [NUM_PINS-1:0] w_core_out [NUM_CORES];
  logic [NUM_PINS-1:0] w_any0 [NUM_CORES];
  logic [NUM_PINS-1:0] w_any1 [NUM_CORES];
  logic [NUM_PINS-1:0] w_wr, w_out_nx, w_drv_nx, w_conf_nx;
  logic [NUM_PINS-1:0] r_gpio_out, r_gpio_drv, r_conflict;
  function automatic int bit_idx(input int c, input int f, input int p);
    return (c * NUM_FSMS + f) * NUM_PINS + p;
  endfunction
  // Per-core merge: first driving FSM from the priority base wins; any0/any1 expose disagreeing drivers
  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      w_core_drv[c] = '0;
      w_core_out[c] = '0;
      w_any0[c] = '0;
      w_any1[c] = '0;
      for (int p = 0; p < NUM_PINS; p++) begin
        for (int k = 0; k < NUM_FSMS; k++) begin
          if (!w_core_drv[c][p] && fsm_drive[bit_idx(c, ((rr_enable[c] ? int'(r_rr_ptr[c]) : 0) + k) % NUM_FSMS, p)]) begin
            w_core_drv[c][p] = 1'b1;
            w_core_out[c][p] = fsm_output[bit_idx(c, ((rr_enable[c] ? int'(r_rr_ptr[c]) : 0) + k) % NUM_FSMS, p)];
          end
          w_any0[c][p] = w_any0[c][p] | (fsm_drive[bit_idx(c, k, p)] & ~fsm_output[bit_idx(c, k, p)]);
          w_any1[c][p] = w_any1[c][p] | (fsm_drive[bit_idx(c, k, p)] & fsm_output[bit_idx(c, k, p)]);
        end
      end
    end
  end
  always_comb begin
    for (int p = 0; p < NUM_PINS; p++) begin
      w_wr[p] = cfg_we && cfg_pin == PW'(p) && {1'b0, cfg_core} < (CW+1)'(NUM_CORES);
      w_state_nx[p] = r_state[p];
      w_sel_nx[p] = r_sel[p];
      w_tgt_nx[p] = r_tgt[p];
      w_hcnt_nx[p] = r_hcnt[p];
      if (r_state[p] == RELEASE) begin
        if (w_wr[p]) begin
          w_tgt_nx[p] = cfg_core;
          w_hcnt_nx[p] = HW'(HANDOVER_CYCLES - 1);
        end else if (r_hcnt[p] == '0) begin
          w_sel_nx[p] = r_tgt[p];
          w_state_nx[p] = ACTIVE;
        end else
          w_hcnt_nx[p] = r_hcnt[p] - HW'(1);
      end else if (w_wr[p] && cfg_core != r_sel[p]) begin
        if (HANDOVER_CYCLES == 0)
          w_sel_nx[p] = cfg_core;
        else begin
          w_tgt_nx[p] = cfg_core;
          w_hcnt_nx[p] = HW'(HANDOVER_CYCLES - 1);
          w_state_nx[p] = RELEASE;
        end
      end
    end
  end
  // A releasing pin is forced undriven and does not evaluate contention
  always_comb begin
    for (int p = 0; p < NUM_PINS; p++) begin
      w_out_nx[p] = r_state[p] == ACTIVE && w_core_out[r_sel[p]][p];
      w_drv_nx[p] = r_state[p] == ACTIVE && w_core_drv[r_sel[p]][p];
      w_conf_nx[p] = (r_state[p] == ACTIVE && w_any0[r_sel[p]][p] && w_any1[r_sel[p]][p]) ||
                     (r_conflict[p] && !conflict_clear[p]);
      handover_busy[p] = r_state[p] == RELEASE;
      core_select_q[p*CW +: CW] = r_sel[p];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '{default: ACTIVE};
      r_sel <= '{default: '0};
      r_tgt <= '{default: '0};
      r_hcnt <= '{default: '0};
      r_rr_ptr <= '{default: '0};
      r_gpio_out <= '0;
      r_gpio_drv <= '0;
      r_conflict <= '0;
    end else begin
      r_state <= w_state_nx;
      r_sel <= w_sel_nx;
      r_tgt <= w_tgt_nx;
      r_hcnt <= w_hcnt_nx;
      for (int c = 0; c < NUM_CORES; c++)
        if (rr_step[c]) r_rr_ptr[c] <= r_rr_ptr[c] == FW'(NUM_FSMS - 1) ? '0 : r_rr_ptr[c] + FW'(1);
      r_gpio_out <= w_out_nx;
      r_gpio_drv <= w_drv_nx;
      r_conflict <= w_conf_nx;
    end
  end
  assign gpio_output = r_gpio_out;
  assign gpio_drive = r_gpio_drv;
  assign conflict = r_conflict;
endmodule

// File: tb/tb_pin_output_mux_seq.sv
// tb_pin_output_mux_seq: scoreboard bench, directed scenarios then random traffic against a pin-level reference model
module tb_pin_output_mux_seq;
  localparam int NC = 4, NF = 4, NP = 32, HC = 2, CW = 2, PW = 5, NB = NC * NF * NP;
  logic clk = 1'b0;
  logic rst;
  logic [NB-1:0] fsm_output, fsm_drive;
  logic [NC-1:0] rr_enable, rr_step;
  logic cfg_we;
  logic [PW-1:0] cfg_pin;
  logic [CW-1:0] cfg_core;
  logic [NP-1:0] conflict_clear, gpio_output, gpio_drive, handover_busy, conflict;
  logic [NP*CW-1:0] core_select_q;
  typedef struct packed {
    logic [NP-1:0] o;
    logic [NP-1:0] d;
    logic [NP-1:0] b;
    logic [NP-1:0] x;
    logic [NP*CW-1:0] s;
  } exp_t;
  exp_t q[$];
  exp_t m_e;
  int vectors = 0, miscompares = 0;
  int m_ptr[NC];
  int m_sel[NP], m_tgt[NP], m_left[NP];
  bit m_conf[NP];
  always #5 clk = ~clk;
  pin_output_mux_seq #(.NUM_CORES(NC), .NUM_FSMS(NF), .NUM_PINS(NP), .HANDOVER_CYCLES(HC)) dut (
    .clk(clk), .rst(rst), .fsm_output(fsm_output), .fsm_drive(fsm_drive),
    .rr_enable(rr_enable), .rr_step(rr_step), .cfg_we(cfg_we), .cfg_pin(cfg_pin),
    .cfg_core(cfg_core), .conflict_clear(conflict_clear), .gpio_output(gpio_output),
    .gpio_drive(gpio_drive), .core_select_q(core_select_q), .handover_busy(handover_busy),
    .conflict(conflict)
  );
  function automatic int idx(input int c, input int f, input int p);
    return (c * NF + f) * NP + p;
  endfunction
  // Reference: m_left counts undriven output cycles still owed to a pending handover
  task automatic model_step();
    exp_t e;
    e = '0;
    if (rst) begin
      for (int c = 0; c < NC; c++) m_ptr[c] = 0;
      for (int p = 0; p < NP; p++) begin
        m_sel[p] = 0;
        m_tgt[p] = 0;
        m_left[p] = 0;
        m_conf[p] = 0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        int c, f, n0, n1;
        bit won, set, wr;
        set = 0;
        if (m_left[p] == 0) begin
          c = m_sel[p];
          won = 0;
          n0 = 0;
          n1 = 0;
          for (int k = 0; k < NF; k++) begin
            f = ((rr_enable[c] ? m_ptr[c] : 0) + k) % NF;
            if (fsm_drive[idx(c, f, p)]) begin
              if (!won) begin
                won = 1;
                e.d[p] = 1'b1;
                e.o[p] = fsm_output[idx(c, f, p)];
              end
              if (fsm_output[idx(c, f, p)]) n1++;
              else n0++;
            end
          end
          set = n0 > 0 && n1 > 0;
        end
        m_conf[p] = set || (m_conf[p] && !conflict_clear[p]);
        wr = cfg_we && int'(cfg_pin) == p && int'(cfg_core) < NC;
        if (m_left[p] > 0) begin
          if (wr) begin
            m_tgt[p] = int'(cfg_core);
            m_left[p] = HC;
          end else begin
            m_left[p]--;
            if (m_left[p] == 0) m_sel[p] = m_tgt[p];
          end
        end else if (wr && int'(cfg_core) != m_sel[p]) begin
          if (HC == 0) m_sel[p] = int'(cfg_core);
          else begin
            m_tgt[p] = int'(cfg_core);
            m_left[p] = HC;
          end
        end
      end
      for (int c = 0; c < NC; c++) if (rr_step[c]) m_ptr[c] = (m_ptr[c] + 1) % NF;
    end
    for (int p = 0; p < NP; p++) begin
      e.b[p] = m_left[p] > 0;
      e.x[p] = m_conf[p];
      e.s[p*CW +: CW] = CW'(m_sel[p]);
    end
    q.push_back(e);
  endtask
  task automatic cycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(negedge clk);
    end
  endtask
  task automatic drv(input int c, input int f, input int p, input bit o);
    fsm_drive[idx(c, f, p)] = 1'b1;
    fsm_output[idx(c, f, p)] = o;
  endtask
  task automatic wr_cfg(input int p, input int c);
    cfg_we = 1'b1;
    cfg_pin = PW'(p);
    cfg_core = CW'(c);
    cycle();
    cfg_we = 1'b0;
  endtask
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    if (a !== x) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, x);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      m_e = q.pop_front();
      vectors++;
      chk("gpio_output", 64'(gpio_output), 64'(m_e.o));
      chk("gpio_drive", 64'(gpio_drive), 64'(m_e.d));
      chk("handover_busy", 64'(handover_busy), 64'(m_e.b));
      chk("conflict", 64'(conflict), 64'(m_e.x));
      chk("core_select_q", 64'(core_select_q), 64'(m_e.s));
    end
  end
  initial begin
    rst = 1'b1;
    fsm_output = '0;
    fsm_drive = '0;
    rr_enable = '0;
    rr_step = '0;
    cfg_we = 1'b0;
    cfg_pin = '0;
    cfg_core = '0;
    conflict_clear = '0;
    cycle(2);
    rst = 1'b0;
    drv(0, 2, 5, 1'b1);
    cycle(2);
    fsm_drive = '0;
    drv(0, 1, 3, 1'b0);
    drv(0, 3, 3, 1'b1);
    cycle(2);
    fsm_drive = '0;
    conflict_clear[3] = 1'b1;
    cycle();
    conflict_clear = '0;
    cycle();
    rr_enable[0] = 1'b1;
    rr_step[0] = 1'b1;
    cycle(3);
    rr_step = '0;
    drv(0, 0, 0, 1'b0);
    drv(0, 3, 0, 1'b1);
    cycle(2);
    rr_step[0] = 1'b1;
    cycle();
    rr_step = '0;
    cycle(2);
    fsm_drive = '0;
    rr_enable = '0;
    drv(0, 0, 7, 1'b0);
    drv(2, 1, 7, 1'b1);
    drv(1, 2, 7, 1'b1);
    cycle();
    wr_cfg(7, 2);
    cycle(4);
    wr_cfg(7, 1);
    cycle();
    wr_cfg(7, 1);
    cycle(4);
    wr_cfg(7, 1);
    cycle(2);
    wr_cfg(7, 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drv(0, 1, 3, 1'b0);
    drv(0, 3, 3, 1'b1);
    cycle();
    conflict_clear[3] = 1'b1;
    cycle(2);
    conflict_clear = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NB; i++) begin
        fsm_drive[i] = $urandom_range(0, 7) == 0;
        fsm_output[i] = 1'($urandom);
      end
      for (int c = 0; c < NC; c++) begin
        rr_step[c] = $urandom_range(0, 5) == 0;
        if ($urandom_range(0, 31) == 0) rr_enable[c] = ~rr_enable[c];
      end
      for (int p = 0; p < NP; p++) conflict_clear[p] = $urandom_range(0, 7) == 0;
      cfg_we = $urandom_range(0, 2) == 0;
      cfg_pin = $urandom_range(0, 1) == 1 ? PW'($urandom_range(0, 3)) : PW'($urandom_range(0, NP - 1));
      cfg_core = CW'($urandom_range(0, NC - 1));
      rst = $urandom_range(0, 299) == 0;
      cycle();
    end
    rst = 1'b0;
    cfg_we = 1'b0;
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
